// File: rtl/master_rx.sv
// Receive-side descrambler for a 1/2/4-lane PIPE interface.
// Gen1/Gen2 LFSR (x^16+x^5+x^4+x^3+1), lanes processed in order within one cycle.
module master_rx #(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        turnOff,
    input  logic [5:0]  PIPEWIDTH,
    input  logic        rxValid,
    input  logic [31:0] rxData,
    input  logic [3:0]  rxDataK,
    output logic [31:0] slaveData,
    output logic [3:0]  slaveDataK,
    output logic        slaveValid
);

    localparam logic [7:0]  K_COM = 8'hBC;
    localparam logic [7:0]  K_SKP = 8'h1C;
    localparam logic [15:0] POLY  = 16'h0039;

    logic [15:0] r_lfsr;
    logic [31:0] r_data;
    logic [3:0]  r_data_k;
    logic        r_valid;

    logic [3:0]  w_lane_active;
    logic [31:0] w_data_out;
    logic [3:0]  w_k_out;
    logic [15:0] w_lfsr_next;

    // Advance the LFSR by eight bit times; upper byte returns the eight
    // output bits (first bit in time at bit 0), lower half the new state.
    function automatic logic [23:0] lfsr_adv8(input logic [15:0] state);
        logic [15:0] s;
        logic [7:0]  m;
        s = state;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            m[b] = s[15];
            s    = {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000);
        end
        return {m, s};
    endfunction

    always_comb begin
        unique case (PIPEWIDTH)
            6'd8:    w_lane_active = 4'b0001;
            6'd16:   w_lane_active = 4'b0011;
            default: w_lane_active = 4'b1111;
        endcase
    end

    // Lane n sees the LFSR left behind by lane n-1 in the same cycle.
    always_comb begin
        logic [15:0] v_lfsr;
        logic [23:0] v_adv;
        logic [7:0]  v_byte;
        logic        v_k;
        w_data_out = '0;
        w_k_out    = '0;
        v_lfsr     = r_lfsr;
        v_adv      = '0;
        v_byte     = '0;
        v_k        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_lane_active[i]) begin
                v_byte     = rxData[8*i +: 8];
                v_k        = rxDataK[i];
                v_adv      = lfsr_adv8(v_lfsr);
                w_k_out[i] = v_k;
                if (turnOff) begin
                    w_data_out[8*i +: 8] = v_byte;
                end else if (v_k && (v_byte == K_COM)) begin
                    w_data_out[8*i +: 8] = v_byte;
                    v_lfsr               = SEED;
                end else if (v_k && (v_byte == K_SKP)) begin
                    w_data_out[8*i +: 8] = v_byte;
                end else if (v_k) begin
                    w_data_out[8*i +: 8] = v_byte;
                    v_lfsr               = v_adv[15:0];
                end else begin
                    w_data_out[8*i +: 8] = v_byte ^ v_adv[23:16];
                    v_lfsr               = v_adv[15:0];
                end
            end
        end
        if (turnOff) begin
            w_lfsr_next = SEED;
        end else if (rxValid) begin
            w_lfsr_next = v_lfsr;
        end else begin
            w_lfsr_next = r_lfsr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr   <= SEED;
            r_data   <= '0;
            r_data_k <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_valid <= rxValid;
            if (rxValid) begin
                r_data   <= w_data_out;
                r_data_k <= w_k_out;
            end
        end
    end

    assign slaveData  = r_data;
    assign slaveDataK = r_data_k;
    assign slaveValid = r_valid;

endmodule

// File: tb/tb_master_rx.sv
// Scoreboard bench for master_rx: a bit-serial reference scrambler model plus
// fixed reference vectors; expected outputs are queued at drive time.
module tb_master_rx;

    localparam logic [15:0] SEED = 16'hFFFF;

    logic        clk;
    logic        reset_n;
    logic        turnOff;
    logic [5:0]  PIPEWIDTH;
    logic        rxValid;
    logic [31:0] rxData;
    logic [3:0]  rxDataK;
    logic [31:0] slaveData;
    logic [3:0]  slaveDataK;
    logic        slaveValid;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr = SEED;
    logic [31:0] m_hold_d = '0;
    logic [3:0]  m_hold_k = '0;

    master_rx #(.SEED(SEED)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .turnOff    (turnOff),
        .PIPEWIDTH  (PIPEWIDTH),
        .rxValid    (rxValid),
        .rxData     (rxData),
        .rxDataK    (rxDataK),
        .slaveData  (slaveData),
        .slaveDataK (slaveDataK),
        .slaveValid (slaveValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference scrambler step for one byte: one bit at a time, tap by tap.
    function automatic void model_lane(input logic [7:0] b, input logic k,
                                       inout logic [15:0] lfsr, output logic [7:0] o);
        logic fb;
        o = b;
        if (k && b == 8'hBC) begin
            lfsr = SEED;
        end else if (!(k && b == 8'h1C)) begin
            for (int n = 0; n < 8; n++) begin
                fb = lfsr[15];
                if (!k) o[n] = b[n] ^ fb;
                lfsr    = {lfsr[14:0], fb};
                lfsr[3] = lfsr[3] ^ fb;
                lfsr[4] = lfsr[4] ^ fb;
                lfsr[5] = lfsr[5] ^ fb;
            end
        end
    endfunction

    task automatic drive(input logic v, input logic toff, input logic [5:0] pw,
                         input logic [31:0] d, input logic [3:0] k,
                         input logic use_exp, input logic [31:0] exp_d);
        int          nl;
        logic [31:0] od;
        logic [3:0]  ok;
        logic [7:0]  ob;
        exp_t        e;
        @(negedge clk);
        rxValid   = v;
        turnOff   = toff;
        PIPEWIDTH = pw;
        rxData    = d;
        rxDataK   = k;
        nl = (pw == 6'd8) ? 1 : (pw == 6'd16) ? 2 : 4;
        if (v) begin
            od = '0;
            ok = '0;
            for (int i = 0; i < nl; i++) begin
                ok[i] = k[i];
                if (toff) begin
                    od[8*i +: 8] = d[8*i +: 8];
                end else begin
                    model_lane(d[8*i +: 8], k[i], m_lfsr, ob);
                    od[8*i +: 8] = ob;
                end
            end
            m_hold_d = use_exp ? exp_d : od;
            m_hold_k = ok;
        end
        if (toff) m_lfsr = SEED;
        e.v = v;
        e.d = m_hold_d;
        e.k = m_hold_k;
        sb_q.push_back(e);
    endtask

    task automatic pulse_reset(input logic toff);
        @(negedge clk);
        rxValid = 1'b0;
        turnOff = toff;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", {63'd0, slaveValid}, 64'd0);
        chk("rst_async_data", {32'd0, slaveData}, 64'd0);
        chk("rst_async_k", {60'd0, slaveDataK}, 64'd0);
        m_lfsr   = SEED;
        m_hold_d = '0;
        m_hold_k = '0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        turnOff = 1'b0;
    endtask

    // Output monitor: one line per transaction only on mismatch.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("valid", {63'd0, slaveValid}, {63'd0, e.v});
                chk("data", {32'd0, slaveData}, {32'd0, e.d});
                chk("datak", {60'd0, slaveDataK}, {60'd0, e.k});
            end else if (reset_n) begin
                chk("idle_valid", {63'd0, slaveValid}, 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  rk;
        logic [5:0]  rpw;
        int          sel;
        int          guard;
        reset_n   = 1'b0;
        turnOff   = 1'b0;
        PIPEWIDTH = 6'd32;
        rxValid   = 1'b0;
        rxData    = '0;
        rxDataK   = '0;
        #1;
        chk("por_valid", {63'd0, slaveValid}, 64'd0);
        chk("por_data", {32'd0, slaveData}, 64'd0);
        chk("por_k", {60'd0, slaveDataK}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // COM in lane 0 then a full cycle of zero data at 4 lanes
        drive(1, 0, 6'd32, 32'h000000BC, 4'b0001, 1, 32'hC017FFBC);
        drive(1, 0, 6'd32, 32'h00000000, 4'b0000, 1, 32'h02E7B214);

        // SKP mid-cycle does not advance; next lane-0 byte continues after 3 bytes
        drive(1, 0, 6'd8,  32'h000000BC, 4'b0001, 1, 32'h000000BC);
        drive(1, 0, 6'd32, 32'h00001C00, 4'b0010, 1, 32'hC0171CFF);
        drive(1, 0, 6'd8,  32'h00000000, 4'b0000, 1, 32'h00000014);

        // Single lane: upper lanes are masked on both data and K
        drive(1, 0, 6'd8,  32'hDEADBEBC, 4'b1111, 1, 32'h000000BC);
        drive(1, 0, 6'd8,  32'hDEADBE00, 4'b0000, 1, 32'h000000FF);
        drive(1, 0, 6'd8,  32'hA5A5A500, 4'b1110, 1, 32'h00000017);
        drive(1, 0, 6'd8,  32'h12345600, 4'b0000, 1, 32'h000000C0);
        drive(1, 0, 6'd8,  32'hFFFFFF00, 4'b0000, 1, 32'h00000014);

        // Bypass, then restart from SEED when turnOff falls
        drive(1, 1, 6'd32, 32'h12345678, 4'b0000, 1, 32'h12345678);
        drive(1, 0, 6'd8,  32'h00000000, 4'b0000, 1, 32'h000000FF);

        // Gap in rxValid: sequence continues unchanged, output held
        drive(1, 0, 6'd8,  32'h000000BC, 4'b0001, 1, 32'h000000BC);
        drive(1, 0, 6'd8,  32'h00000000, 4'b0000, 1, 32'h000000FF);
        drive(0, 0, 6'd8,  32'h00000077, 4'b0000, 0, 32'h0);
        drive(1, 0, 6'd8,  32'h00000000, 4'b0000, 1, 32'h00000017);
        drive(1, 0, 6'd8,  32'h00000000, 4'b0000, 1, 32'h000000C0);

        // Randomised stream checked against the reference model
        for (int c = 0; c < 60; c++) begin
            sel = $urandom_range(0, 3);
            rpw = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32 : 6'd5;
            rd  = $urandom;
            rk  = '0;
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rk[l] = 1'b1;
                    sel   = $urandom_range(0, 2);
                    rd[8*l +: 8] = (sel == 0) ? 8'hBC : (sel == 1) ? 8'h1C : 8'hF7;
                end
            end
            drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                  rpw, rd, rk, 0, 32'h0);
        end
        drive(1, 0, 6'd32, 32'h00000000, 4'b0000, 0, 32'h0);

        // Reset mid-stream discards LFSR state; no COM needed afterwards
        pulse_reset(1'b0);
        drive(1, 0, 6'd8, 32'h00000000, 4'b0000, 1, 32'h000000FF);
        drive(1, 0, 6'd8, 32'h00000000, 4'b0000, 1, 32'h00000017);
        drive(1, 0, 6'd8, 32'h00000000, 4'b0000, 1, 32'h000000C0);
        drive(1, 0, 6'd8, 32'h00000000, 4'b0000, 1, 32'h00000014);

        // Reset while bypassed behaves the same
        pulse_reset(1'b1);
        drive(1, 0, 6'd16, 32'h00000000, 4'b0000, 1, 32'h000017FF);
        drive(0, 0, 6'd16, 32'h00000000, 4'b0000, 0, 32'h0);
        drive(0, 0, 6'd16, 32'h00000000, 4'b0000, 0, 32'h0);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("drain", {32'd0, sb_q.size()}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
